// File: rtl/mem_byte_streamer.sv
// Streams a run of 64-bit memory words out as an LSB-first 8-bit valid/ready byte stream.
// Optional abort input is enabled by defining MEM_STREAM_ABORT_EN.
module mem_byte_streamer #(
    parameter int ADDR_WIDTH = 11,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [63:0]           mem_rdata,
    output logic [7:0]            tdata,
    output logic                  tvalid,
    input  logic                  tready,
`ifdef MEM_STREAM_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  tlast
);

    localparam int SEND_WIDTH = CNT_WIDTH + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [CNT_WIDTH-1:0]    fetch_left;
    logic [SEND_WIDTH-1:0]   send_left;
    logic                    inflight;
    logic [63:0]             sr_data;
    logic [2:0]              sr_idx;
    logic                    sr_full;
    logic [63:0]             hr_data;
    logic                    hr_full;

    logic abort_req;
    logic handshake;
    logic sr_last_hs;
    logic sr_free;
    logic start_run;
    logic flush;
    logic final_hs;

`ifdef MEM_STREAM_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign handshake  = sr_full && tready;
    assign sr_last_hs = handshake && (sr_idx == 3'd7);
    assign sr_free    = !sr_full || sr_last_hs;
    assign start_run  = (state == S_IDLE) && start && (word_count != '0);
    assign flush      = (state == S_RUN) && abort_req;
    assign final_hs   = handshake && (send_left == SEND_WIDTH'(1));

    // A read is only issued when its data is guaranteed a landing place (HR empty, nothing in flight).
    assign mem_en   = (state == S_RUN) && (fetch_left != '0) && !inflight && !hr_full && !abort_req;
    assign mem_addr = rd_ptr;

    assign tvalid = sr_full;
    assign tdata  = sr_data[{sr_idx, 3'b000} +: 8];
    assign tlast  = sr_full && (send_left == SEND_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (word_count != '0) begin
                            state <= S_RUN;
                        end else begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort_req || final_hs) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Returning read data takes priority over HR for refilling SR, which keeps word order intact
    // because HR is always empty whenever a read is in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr     <= '0;
            fetch_left <= '0;
            send_left  <= '0;
            inflight   <= 1'b0;
            sr_data    <= '0;
            sr_idx     <= '0;
            sr_full    <= 1'b0;
            hr_data    <= '0;
            hr_full    <= 1'b0;
        end else if (flush) begin
            fetch_left <= '0;
            inflight   <= 1'b0;
            sr_idx     <= '0;
            sr_full    <= 1'b0;
            hr_full    <= 1'b0;
        end else begin
            if (start_run) begin
                rd_ptr     <= base_addr;
                fetch_left <= word_count;
                send_left  <= {word_count, 3'b000};
            end else begin
                if (mem_en) begin
                    rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
                    fetch_left <= fetch_left - CNT_WIDTH'(1);
                end
                if (handshake) begin
                    send_left <= send_left - SEND_WIDTH'(1);
                end
            end

            inflight <= mem_en;

            if (inflight && sr_free) begin
                sr_data <= mem_rdata;
                sr_idx  <= '0;
                sr_full <= 1'b1;
            end else if (inflight) begin
                hr_data <= mem_rdata;
                hr_full <= 1'b1;
                if (handshake) begin
                    sr_idx <= sr_idx + 3'd1;
                end
            end else if (hr_full && sr_free) begin
                sr_data <= hr_data;
                sr_idx  <= '0;
                sr_full <= 1'b1;
                hr_full <= 1'b0;
            end else if (handshake) begin
                sr_idx <= sr_idx + 3'd1;
                if (sr_idx == 3'd7) begin
                    sr_full <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_streamer.sv
// Scoreboard bench for mem_byte_streamer: a word-level memory model predicts the byte stream and read addresses.
// Abort scenario is exercised only when MEM_STREAM_ABORT_EN is defined.
module tb_mem_byte_streamer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] word_count;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic [10:0] mem_addr;
    logic [63:0] mem_rdata;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
`ifdef MEM_STREAM_ABORT_EN
    logic        abort;
`endif

    always #5 clk = ~clk;

    mem_byte_streamer dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tready     (tready),
`ifdef MEM_STREAM_ABORT_EN
        .abort      (abort),
`endif
        .tlast      (tlast)
    );

    logic [63:0] mem [0:2047];

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_q[$];
    logic [10:0] addr_q[$];

    int c0 = 0;
    int mem_en_cnt, tvalid_cnt, byte_cnt, done_cnt;
    int first_en_rel, first_tv_rel, last_byte_rel, done_rel;
    int mon_rel;
    int tready_mode = 0;
    logic mon_stall_en = 1'b1;
    logic prev_stall = 1'b0;
    logic prev_en = 1'b0;
    logic [8:0] prev_byte = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every read issue and every byte handshake against the scoreboard queues.
    always @(negedge clk) begin
        mon_rel = cyc - c0 + 1;
        if (rstn) begin
            if (mem_en) begin
                mem_en_cnt++;
                if (first_en_rel < 0) first_en_rel = mon_rel;
                checkOutput("mem_en only while busy", 64'(busy), 64'(1));
                checkOutput("single read in flight", 64'(prev_en), 64'(0));
                if (addr_q.size() == 0) checkOutput("unexpected mem_en", 64'(addr_q.size()), 64'(1));
                else checkOutput("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
            end
            if (tvalid) begin
                tvalid_cnt++;
                if (first_tv_rel < 0) first_tv_rel = mon_rel;
                if (mon_stall_en && prev_stall) checkOutput("stall hold tlast/tdata", 64'({tlast, tdata}), 64'(prev_byte));
                if (tready) begin
                    byte_cnt++;
                    last_byte_rel = mon_rel;
                    if (exp_q.size() == 0) checkOutput("unexpected byte", 64'(exp_q.size()), 64'(1));
                    else checkOutput("tlast/tdata", 64'({tlast, tdata}), 64'(exp_q.pop_front()));
                end
            end else if (mon_stall_en && prev_stall) begin
                checkOutput("tvalid held during stall", 64'(tvalid), 64'(1));
            end
            if (done) begin
                done_cnt++;
                done_rel = mon_rel;
            end
        end
        prev_stall = tvalid && !tready;
        prev_en    = mem_en;
        prev_byte  = {tlast, tdata};
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (tready_mode)
            0:       tready = 1'b0;
            1:       tready = 1'b1;
            default: tready = ($urandom_range(0, 1) == 1);
        endcase
    endtask

    // Issues one command and pushes the predicted addresses and bytes into the scoreboard.
    task automatic applyStimulus(input logic [10:0] b, input logic [11:0] n);
        logic [10:0] a;
        logic [63:0] w;
        tick();
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 11'(i);
            w = mem[a];
            addr_q.push_back(a);
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back({(i == int'(n) - 1) && (k == 7), w[8*k +: 8]});
            end
        end
        mem_en_cnt = 0; tvalid_cnt = 0; byte_cnt = 0; done_cnt = 0;
        first_en_rel = -1; first_tv_rel = -1; last_byte_rel = -1; done_rel = -1;
        tick();
        start = 1'b0;
        c0    = cyc;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) checkOutput("done timeout", 64'(done_cnt), 64'(1));
    endtask

    task automatic waitBytes(input int target, input int budget);
        int n = 0;
        while (byte_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (byte_cnt < target) checkOutput("byte count timeout", 64'(byte_cnt), 64'(target));
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, " byte queue drained"}, 64'(exp_q.size()), 64'(0));
        checkOutput({tag, " addr queue drained"}, 64'(addr_q.size()), 64'(0));
    endtask

    task automatic runSingleWord();
        tready_mode = 1;
        applyStimulus(11'h000, 12'd1);
        waitDone(100);
        @(negedge clk);
        checkOutput("t1 busy after done", 64'(busy), 64'(0));
        checkOutput("t1 first mem_en cycle", 64'(first_en_rel), 64'(1));
        checkOutput("t1 first tvalid cycle", 64'(first_tv_rel), 64'(3));
        checkOutput("t1 last byte cycle", 64'(last_byte_rel), 64'(10));
        checkOutput("t1 done cycle", 64'(done_rel), 64'(11));
        checkOutput("t1 mem_en count", 64'(mem_en_cnt), 64'(1));
        checkOutput("t1 byte count", 64'(byte_cnt), 64'(8));
        checkOutput("t1 done count", 64'(done_cnt), 64'(1));
        checkDrained("t1");
    endtask

    initial begin
        int en_before;
        for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h0807060504030201;

        rstn = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; tready = 1'b0;
`ifdef MEM_STREAM_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset done", 64'(done), 64'(0));
        checkOutput("reset mem_en", 64'(mem_en), 64'(0));
        checkOutput("reset mem_addr", 64'(mem_addr), 64'(0));
        checkOutput("reset tvalid", 64'(tvalid), 64'(0));
        checkOutput("reset tdata", 64'(tdata), 64'(0));
        checkOutput("reset tlast", 64'(tlast), 64'(0));
        rstn = 1'b1;
        repeat (2) tick();

        $display("[TB] single word from address 0");
        runSingleWord();

        $display("[TB] four words wrapping at the top of memory");
        tready_mode = 1;
        applyStimulus(11'h7FE, 12'd4);
        waitDone(200);
        checkOutput("t2 first tvalid cycle", 64'(first_tv_rel), 64'(3));
        checkOutput("t2 last byte cycle (no bubbles)", 64'(last_byte_rel), 64'(34));
        checkOutput("t2 done cycle", 64'(done_rel), 64'(35));
        checkOutput("t2 byte count", 64'(byte_cnt), 64'(32));
        checkOutput("t2 mem_en count", 64'(mem_en_cnt), 64'(4));
        checkDrained("t2");

        $display("[TB] three words with random and stalled consumer");
        tready_mode = 2;
        applyStimulus(11'($urandom_range(0, 2047)), 12'd3);
        repeat (10) tick();
        tready_mode = 0;
        tick();
        start = 1'b1; base_addr = 11'h123; word_count = 12'd1;
        tick();
        start = 1'b0;
        repeat (18) tick();
        checkOutput("t3 reads bounded while stalled", 64'(mem_en_cnt <= 3), 64'(1));
        checkOutput("t3 busy while stalled", 64'(busy), 64'(1));
        tready_mode = 2;
        waitDone(2000);
        repeat (3) tick();
        checkOutput("t3 mem_en count", 64'(mem_en_cnt), 64'(3));
        checkOutput("t3 byte count", 64'(byte_cnt), 64'(24));
        checkOutput("t3 done count", 64'(done_cnt), 64'(1));
        checkDrained("t3");

        $display("[TB] zero-length command");
        tready_mode = 1;
        applyStimulus(11'($urandom_range(0, 2047)), 12'd0);
        @(negedge clk);
        checkOutput("t4 done in cycle 1", 64'(done), 64'(1));
        checkOutput("t4 busy in cycle 1", 64'(busy), 64'(1));
        @(negedge clk);
        checkOutput("t4 busy in cycle 2", 64'(busy), 64'(0));
        checkOutput("t4 done in cycle 2", 64'(done), 64'(0));
        repeat (8) tick();
        checkOutput("t4 mem_en count", 64'(mem_en_cnt), 64'(0));
        checkOutput("t4 tvalid count", 64'(tvalid_cnt), 64'(0));
        checkOutput("t4 done count", 64'(done_cnt), 64'(1));

        $display("[TB] reset in the middle of a run");
        tready_mode = 1;
        applyStimulus(11'($urandom_range(0, 2047)), 12'd2);
        waitBytes(5, 100);
        mon_stall_en = 1'b0;
        tready_mode  = 0;
        tready       = 1'b0;
        rstn         = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("t5 busy after reset", 64'(busy), 64'(0));
        checkOutput("t5 mem_en after reset", 64'(mem_en), 64'(0));
        checkOutput("t5 mem_addr after reset", 64'(mem_addr), 64'(0));
        checkOutput("t5 tvalid after reset", 64'(tvalid), 64'(0));
        checkOutput("t5 tdata after reset", 64'(tdata), 64'(0));
        checkOutput("t5 tlast after reset", 64'(tlast), 64'(0));
        exp_q.delete();
        addr_q.delete();
        repeat (10) tick();
        checkOutput("t5 no done after reset", 64'(done_cnt), 64'(0));
        mon_stall_en = 1'b1;
        runSingleWord();

`ifdef MEM_STREAM_ABORT_EN
        $display("[TB] abort during a four word run");
        tready_mode = 1;
        applyStimulus(11'($urandom_range(0, 2047)), 12'd4);
        waitBytes(10, 100);
        mon_stall_en = 1'b0;
        en_before    = mem_en_cnt;
        abort        = 1'b1;
        tready       = 1'b0;
        tick();
        abort = 1'b0;
        @(negedge clk);
        checkOutput("t6 tvalid after abort", 64'(tvalid), 64'(0));
        exp_q.delete();
        addr_q.delete();
        waitDone(20);
        repeat (10) tick();
        checkOutput("t6 done count", 64'(done_cnt), 64'(1));
        checkOutput("t6 no mem_en after abort", 64'(mem_en_cnt), 64'(en_before));
        checkOutput("t6 idle after abort", 64'(busy), 64'(0));
        mon_stall_en = 1'b1;
`else
        en_before = 0;
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got t=%0t, expected < 1000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
